// File: rtl/fft_bank_scheduler.sv
// Ping-pong bank scheduler between an FFT AXI-Stream output and a BRAM writer.
// Frames fill one of two banks; the consumer releases banks once it has drained them.
module fft_bank_scheduler #(
  parameter int BEATS_PER_FRAME = 256,
  parameter int BANK_BYTES      = 8192
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        fft_tvalid,
  input  logic        fft_tlast,
  output logic        fft_tready,
  output logic        wr_tvalid,
  input  logic        wr_tready,
  output logic [31:0] wr_base_addr,
  output logic        fill_bank,
  output logic [1:0]  bank_full,
  input  logic        rd_release,
  input  logic        rd_release_bank,
  output logic        irq_frame,
  output logic        err_short,
  output logic        err_long,
  input  logic        err_clear
);

  typedef enum logic [1:0] {
    S_WAIT,
    S_FILL,
    S_DONE
  } state_t;

  localparam logic [8:0]  LAST_COUNT  = 9'(BEATS_PER_FRAME);
  localparam logic [31:0] BANK_STRIDE = 32'(BANK_BYTES);

  state_t      state;
  state_t      state_next;
  logic [8:0]  beat_cnt;
  logic [8:0]  beat_cnt_next;
  logic [8:0]  cnt_inc;
  logic        gate;
  logic        beat;
  logic        close_beat;
  logic        short_hit;
  logic        long_hit;
  logic [1:0]  full_next;

  assign gate       = (state == S_FILL);
  assign fft_tready = wr_tready & gate;
  assign wr_tvalid  = fft_tvalid & gate;
  assign beat       = fft_tvalid & fft_tready;
  assign cnt_inc    = beat_cnt + 9'd1;

  // Frame closes on tlast or on reaching the nominal beat count, whichever is first.
  always_comb begin
    state_next    = state;
    beat_cnt_next = beat_cnt;
    close_beat    = 1'b0;
    short_hit     = 1'b0;
    long_hit      = 1'b0;
    case (state)
      S_WAIT: begin
        if (run && !bank_full[fill_bank]) begin
          state_next    = S_FILL;
          beat_cnt_next = '0;
        end
      end
      S_FILL: begin
        if (beat) begin
          beat_cnt_next = cnt_inc;
          if (fft_tlast || (cnt_inc == LAST_COUNT)) begin
            state_next = S_DONE;
            close_beat = 1'b1;
            short_hit  = fft_tlast && (cnt_inc < LAST_COUNT);
            long_hit   = !fft_tlast && (cnt_inc == LAST_COUNT);
          end
        end
      end
      S_DONE:  state_next = S_WAIT;
      default: state_next = S_WAIT;
    endcase
  end

  // Release is applied first so a same-bank set in S_DONE overrides it.
  always_comb begin
    full_next = bank_full;
    if (rd_release) full_next[rd_release_bank] = 1'b0;
    if (state == S_DONE) full_next[fill_bank] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_WAIT;
      beat_cnt <= '0;
    end else begin
      state    <= state_next;
      beat_cnt <= beat_cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_full    <= 2'b00;
      fill_bank    <= 1'b0;
      wr_base_addr <= '0;
    end else begin
      bank_full <= full_next;
      if (state == S_DONE) begin
        fill_bank    <= ~fill_bank;
        wr_base_addr <= fill_bank ? '0 : BANK_STRIDE;
      end
    end
  end

  // A new error outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_frame <= 1'b0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else begin
      irq_frame <= close_beat;
      err_short <= (err_short & ~err_clear) | short_hit;
      err_long  <= (err_long & ~err_clear) | long_hit;
    end
  end

endmodule

// File: doc/fft_bank_scheduler.md
FFT_BANK_SCHEDULER -- requirements
Module: fft_bank_scheduler

Interface
REQ-001 SHALL have parameter BEATS_PER_FRAME, default 256, meaning FFT beats (8 mics each) per frame.
REQ-002 SHALL have parameter BANK_BYTES, default 8192, meaning byte span of one BRAM bank (2048 words x 4 B).
REQ-003 SHALL have ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- run  in  1  capture enable.
- fft_tvalid  in  1  FFT stream valid.
- fft_tlast  in  1  FFT stream last.
- fft_tready  out  1  ready to FFT.
- wr_tvalid  out  1  valid to BRAM writer.
- wr_tready  in  1  ready from BRAM writer.
- wr_base_addr  out  32  byte base of the bank being filled.
- fill_bank  out  1  index of the bank being filled.
- bank_full  out  2  per-bank "frame ready for consumer" flags.
- rd_release  in  1  consumer release strobe.
- rd_release_bank  in  1  bank index released.
- irq_frame  out  1  one-cycle pulse per completed frame.
- err_short  out  1  sticky: tlast before the full beat count.
- err_long  out  1  sticky: full beat count reached without tlast.
- err_clear  in  1  clears both error flags.

Function
REQ-004 SHALL implement states S_WAIT, S_FILL and S_DONE.
REQ-005 gate = (state == S_FILL); fft_tready = wr_tready & gate; wr_tvalid = fft_tvalid & gate; both combinational.
REQ-006 beat = fft_tvalid & fft_tready.
REQ-007 S_WAIT -> S_FILL when run = 1 and bank_full[fill_bank] = 0; beat counter cleared on entry to S_FILL.
REQ-008 In S_FILL, each beat increments the 9-bit beat counter.
REQ-009 The frame SHALL close on a beat carrying fft_tlast, or on the beat that makes count = BEATS_PER_FRAME, whichever comes first; S_FILL -> S_DONE.
REQ-010 Closing beat with tlast = 1 and count < BEATS_PER_FRAME sets err_short; count reaching BEATS_PER_FRAME with tlast = 0 sets err_long; the frame closes in both cases.
REQ-011 S_DONE, single cycle:
- set bank_full[fill_bank];
- pulse irq_frame;
- toggle fill_bank;
- go to S_WAIT.
REQ-012 wr_base_addr = fill_bank * BANK_BYTES, registered with fill_bank; no change while in S_FILL.
REQ-013 rd_release in any state clears bank_full[rd_release_bank]; release of an already-empty bank is ignored.
REQ-014 Release and S_DONE set for the same bank in the same cycle: the set wins.
REQ-015 Release and S_DONE on different banks in the same cycle: both take effect.
REQ-016 run deasserted during S_FILL: the current frame completes normally, then the block holds in S_WAIT.
REQ-017 Both banks full: the block SHALL hold in S_WAIT with fft_tready = 0; no data is dropped or overwritten.
REQ-018 err_clear clears err_short and err_long; if err_clear coincides with a new error, the error flag SHALL be set.
REQ-019 Latency: irq_frame is asserted on the cycle after the closing beat; fft_tready first rises on the cycle after entry to S_FILL.

Reset
REQ-020 Asynchronous assertion of rst_n SHALL immediately force:
- state = S_WAIT;
- fill_bank = 0, wr_base_addr = 0;
- bank_full = 2'b00;
- beat counter = 0;
- irq_frame = 0, err_short = 0, err_long = 0;
- fft_tready = 0, wr_tvalid = 0.
REQ-021 Reset mid-frame SHALL discard the partial frame; after release, filling restarts at bank 0.

Verification
REQ-022 Scenario: run = 1, 256 beats with tlast on beat 256, wr_tready = 1 -> one irq_frame pulse, bank_full = 01, fill_bank = 1, wr_base_addr = 0x2000, no errors.
REQ-023 Scenario: two full frames with no release -> bank_full = 11, fft_tready held 0 while a third frame is offered; release bank 0 -> filling resumes at wr_base_addr = 0.
REQ-024 Scenario: tlast on beat 100 -> err_short = 1, frame closed, bank_full set; next: 256 beats without tlast -> err_long = 1; err_clear -> both flags 0.
REQ-025 Scenario: rd_release of bank 0 in the same cycle as S_DONE on bank 0 -> bank_full[0] = 1 afterward; release of empty bank 1 -> no change.
REQ-026 Scenario: wr_tready toggled randomly during a frame -> exactly 256 beats counted, and wr_tvalid/fft_tready follow REQ-005 every cycle.
REQ-027 Scenario: rst_n pulsed low at beat 50 -> all outputs at reset values within the same cycle; next frame fills bank 0 from beat 0.
